sram_axi_arbiter: RTL and testbench

- Shares one AXI3 master port between two SRAM-like requesters: the instruction-fetch port (inst_sram_*) and the data-memory port (data_sram_*).
- Arbitrates reads, tags each read with an ARID, and routes R beats back to the owner by RID.
- Sequences single-beat data writes through AW/W/B.
- Blocks data reads that could overtake a pending write (read-after-write hazard).

---
 rtl/sram_axi_arbiter_pkg.sv | 21 ++
 rtl/sram_axi_arbiter_wr_ctrl.sv | 71 +++++++
 rtl/sram_axi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_arbiter_pkg.sv
// sram_axi_arbiter_pkg: ARID tags, fixed AXI field values and write FSM encoding for sram_axi_arbiter
package sram_axi_arbiter_pkg;
    localparam logic [3:0] ARID_INST = 4'd0;
    localparam logic [3:0] ARID_DATA = 4'd1;
    localparam logic [3:0] AWID_DATA = 4'd1;
    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction
endpackage

// File: rtl/sram_axi_arbiter_wr_ctrl.sv
// sram_axi_arbiter_wr_ctrl: single-beat data write sequencer driving AW/W and waiting for B
module sram_axi_arbiter_wr_ctrl
    import sram_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [3:0]        req_wstrb,
    input  logic [31:0]       req_wdata,
    output logic              accept,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid
);
    w_state_t state, state_nxt;

    assign busy = state != W_IDLE;

    // write FSM state register
    always_ff @(posedge clk)
        state <= !resetn ? W_IDLE : state_nxt;

    // next state, request accept and response strobe; W_SEND exits once each channel has handshaked
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            W_IDLE: if (req) begin
                accept    = 1'b1;
                state_nxt = W_SEND;
            end
            W_SEND: if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = W_RESP;
            W_RESP: if (bvalid) begin
                done      = 1'b1;
                state_nxt = W_IDLE;
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    // latch the write on accept; AW and W valids drop independently on their own handshakes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (accept) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= req_addr;
            awsize  <= axi_size(req_size);
            wstrb   <= req_wstrb;
            wdata   <= req_wdata;
        end else begin
            awvalid <= awvalid && !awready;
            wvalid  <= wvalid && !wready;
        end
    end
endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares one AXI3 master between inst and data SRAM ports; ARB_RAW_ADDR_CMP_EN limits RAW blocking to same-word reads
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    logic [1:0] cnt_inst, cnt_data;
    logic       wr_req, wr_accept, wr_done, wr_busy, raw_block;
    logic       data_rd_grant, inst_grant, r_inst, r_data;
    logic       unused;

    assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, bid, bresp};

    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign awid    = AWID_DATA;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign wid     = AWID_DATA;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

`ifdef ARB_RAW_ADDR_CMP_EN
    assign raw_block = wr_busy && data_sram_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2];
`else
    assign raw_block = wr_busy;

    // every data read waits out a pending write, so a data R beat can never meet a B response
    always_ff @(posedge clk)
        if (resetn) assert (!(bvalid && r_data));
`endif

    assign data_rd_grant = resetn && !arvalid && data_sram_req && !data_sram_wr && cnt_data != MAX_CNT && !raw_block;
    assign inst_grant    = resetn && !arvalid && inst_sram_req && !data_rd_grant && cnt_inst != MAX_CNT;
    assign wr_req        = resetn && data_sram_req && data_sram_wr && cnt_data == 2'd0;

    assign r_inst = rvalid && rid == ARID_INST;
    assign r_data = rvalid && rid == ARID_DATA;

    assign inst_sram_addr_ok = inst_grant;
    assign data_sram_addr_ok = data_rd_grant || wr_accept;
    assign inst_sram_data_ok = resetn && r_inst;
    assign inst_sram_rdata   = rdata;
    assign data_sram_data_ok = resetn && (wr_done || r_data);
    assign data_sram_rdata   = rdata;

    // single AR slot: load the winner on grant, free it on the AR handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid <= 1'b0;
        end else if (inst_grant || data_rd_grant) begin
            arvalid <= 1'b1;
            arid    <= data_rd_grant ? ARID_DATA : ARID_INST;
            araddr  <= data_rd_grant ? data_sram_addr : inst_sram_addr;
            arsize  <= axi_size(data_rd_grant ? data_sram_size : inst_sram_size);
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // in-flight read counts: up on grant, down on the owner's last R beat
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_inst <= 2'd0;
            cnt_data <= 2'd0;
        end else begin
            cnt_inst <= cnt_inst + 2'(inst_grant) - 2'(r_inst && rlast);
            cnt_data <= cnt_data + 2'(data_rd_grant) - 2'(r_data && rlast);
        end
    end

    sram_axi_arbiter_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr (
        .clk      (clk),
        .resetn   (resetn),
        .req      (wr_req),
        .req_addr (data_sram_addr),
        .req_size (data_sram_size),
        .req_wstrb(data_sram_wstrb),
        .req_wdata(data_sram_wdata),
        .accept   (wr_accept),
        .done     (wr_done),
        .busy     (wr_busy),
        .awaddr   (awaddr),
        .awsize   (awsize),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid)
    );
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: random inst/data traffic against a transaction-level AXI slave, rule model and response scoreboard
`timescale 1ns/1ps
module tb_sram_axi_arbiter;
    localparam int MAX = 2;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_axi_arbiter #(.MAX_OUTSTANDING(MAX), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;
    typedef struct packed {logic wr; logic [31:0] data;} dr_t;
    typedef struct packed {logic [31:0] addr; logic [2:0] size;} aw_t;
    typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;
    typedef struct packed {logic [3:0] id; logic [31:0] addr;} rd_t;

    logic [31:0] inst_exp_q[$];
    dr_t         data_exp_q[$];
    ar_t         ar_exp_q[$];
    aw_t         aw_exp_q[$];
    w_t          w_exp_q[$];
`ifdef ARB_RAW_ADDR_CMP_EN
    logic [31:0] wr_addr = 32'd0;
`endif

    int n_chk = 0, n_fail = 0;
    int p_ar = 70, p_r = 60, p_aw = 70, p_w = 50, p_b = 60;
    bit gen_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // slave memory contents: 0x1C000000 reads back as 0x12345678
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0E34_5678;
    endfunction

    // environment: requesters, AXI slave and the arbitration rule model, one pass per clock
    initial begin : env
        int oi, od;
        bit ar_busy, wp, aw_done, w_done, r_real, rst_prev, rst_now;
        bit i_ok, d_rd_ok, d_wr_ok, blk, ar_hs, aw_hs, w_hs, r_hs, b_hs;
        logic [3:0]  s_arid;
        logic [31:0] s_araddr;
        rd_t rd_q[$];
        oi = 0; od = 0; ar_busy = 0; wp = 0; aw_done = 0; w_done = 0; r_real = 0; rst_prev = 0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0; awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
        forever begin
            @(negedge clk);
            rst_now = !resetn;
            if (rst_prev) begin
                chk("rst_arvalid", 32'(arvalid), 32'd0);
                chk("rst_awvalid", 32'(awvalid), 32'd0);
                chk("rst_wvalid", 32'(wvalid), 32'd0);
            end
            blk = wp;
`ifdef ARB_RAW_ADDR_CMP_EN
            blk = wp && data_sram_addr[31:2] == wr_addr[31:2];
`endif
            d_rd_ok = resetn && data_sram_req && !data_sram_wr && !ar_busy && od < MAX && !blk;
            d_wr_ok = resetn && data_sram_req && data_sram_wr && !wp && od == 0;
            i_ok    = resetn && inst_sram_req && !ar_busy && oi < MAX && !d_rd_ok;
            chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(i_ok));
            chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(d_rd_ok || d_wr_ok));
            if (i_ok) begin
                ar_exp_q.push_back({4'd0, inst_sram_addr, {1'b0, inst_sram_size}});
                inst_exp_q.push_back(mem_word(inst_sram_addr));
            end
            if (d_rd_ok) begin
                ar_exp_q.push_back({4'd1, data_sram_addr, {1'b0, data_sram_size}});
                data_exp_q.push_back({1'b0, mem_word(data_sram_addr)});
            end
            if (d_wr_ok) begin
                aw_exp_q.push_back({data_sram_addr, {1'b0, data_sram_size}});
                w_exp_q.push_back({data_sram_wdata, data_sram_wstrb});
                data_exp_q.push_back({1'b1, 32'd0});
            end
            ar_hs = arvalid && arready; s_arid = arid; s_araddr = araddr;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; r_hs = rvalid; b_hs = bvalid;
            @(posedge clk);
            #1;
            rst_prev = rst_now;
            if (rst_now) begin
                oi = 0; od = 0; ar_busy = 0; wp = 0; aw_done = 0; w_done = 0;
                rd_q.delete(); inst_exp_q.delete(); data_exp_q.delete(); ar_exp_q.delete(); aw_exp_q.delete(); w_exp_q.delete();
            end else begin
                if (i_ok || d_rd_ok) ar_busy = 1;
                if (ar_hs) begin
                    ar_busy = 0;
                    rd_q.push_back({s_arid, s_araddr});
                end
                oi += int'(i_ok);
                od += int'(d_rd_ok);
                if (r_hs && r_real) begin
                    void'(rd_q.pop_front());
                    if (rid == 4'd0) oi--; else od--;
                end
                if (d_wr_ok) begin
                    wp = 1;
`ifdef ARB_RAW_ADDR_CMP_EN
                    wr_addr = data_sram_addr;
`endif
                end
                if (aw_hs) aw_done = 1;
                if (w_hs) w_done = 1;
                if (b_hs) begin
                    wp = 0; aw_done = 0; w_done = 0;
                end
            end
            if (!inst_sram_req || i_ok) begin
                inst_sram_req   = gen_on && roll(60);
                inst_sram_addr  = 32'h1C00_0000 + 32'($urandom_range(0, 15)) * 4;
                inst_sram_wr    = 1'($urandom_range(0, 1));
                inst_sram_size  = 2'd2;
                inst_sram_wstrb = 4'($urandom);
                inst_sram_wdata = $urandom;
            end
            if (!data_sram_req || d_rd_ok || d_wr_ok) begin
                data_sram_req   = gen_on && roll(50);
                data_sram_wr    = roll(35);
                data_sram_addr  = 32'h100 * (32'($urandom_range(0, 1)) + 1) + 32'($urandom_range(0, 3)) * 4;
                data_sram_size  = 2'($urandom_range(0, 2));
                data_sram_wstrb = 4'($urandom);
                data_sram_wdata = $urandom;
            end
            arready = roll(p_ar);
            awready = roll(p_aw);
            wready  = roll(p_w);
            rresp   = 2'($urandom);
            bresp   = 2'($urandom);
            rvalid  = 0;
            r_real  = 0;
            if (rd_q.size() != 0 && roll(p_r)) begin
                rvalid = 1; r_real = 1; rid = rd_q[0].id; rdata = mem_word(rd_q[0].addr);
            end else if (p_r != 0 && roll(3)) begin
                rvalid = 1; rid = 4'($urandom_range(2, 15)); rdata = $urandom;
            end
            bvalid = aw_done && w_done && roll(p_b);
        end
    end

    // monitor: checks AXI requests and SRAM responses against the scoreboard queues
    initial begin : mon
        ar_t a;
        aw_t aw;
        w_t  w;
        dr_t d;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (inst_sram_data_ok) begin
                    if (inst_exp_q.size() == 0) chk("inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
                    else chk("inst_rdata", inst_sram_rdata, inst_exp_q.pop_front());
                end
                if (data_sram_data_ok) begin
                    if (data_exp_q.size() == 0) chk("data_data_ok", 32'(data_sram_data_ok), 32'd0);
                    else begin
                        d = data_exp_q.pop_front();
                        chk("data_resp_kind", 32'(bvalid), 32'(d.wr));
                        if (!d.wr) chk("data_rdata", data_sram_rdata, d.data);
                    end
                end
                if (arvalid && arready) begin
                    if (ar_exp_q.size() == 0) chk("ar_unexpected", 32'(arvalid), 32'd0);
                    else begin
                        a = ar_exp_q.pop_front();
                        chk("arid", 32'(arid), 32'(a.id));
                        chk("araddr", araddr, a.addr);
                        chk("arsize", 32'(arsize), 32'(a.size));
                        chk("ar_const", 32'({arlen, arburst, arlock, arcache, arprot, rready, bready}), 32'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1, 1'b1}));
                    end
                end
                if (awvalid && awready) begin
                    if (aw_exp_q.size() == 0) chk("aw_unexpected", 32'(awvalid), 32'd0);
                    else begin
                        aw = aw_exp_q.pop_front();
                        chk("awaddr", awaddr, aw.addr);
                        chk("awsize", 32'(awsize), 32'(aw.size));
                        chk("aw_const", 32'({awid, awlen, awburst, awlock, awcache, awprot, wid, wlast}), 32'({4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1}));
                    end
                end
                if (wvalid && wready) begin
                    if (w_exp_q.size() == 0) chk("w_unexpected", 32'(wvalid), 32'd0);
                    else begin
                        w = w_exp_q.pop_front();
                        chk("wdata", wdata, w.data);
                        chk("wstrb", 32'(wstrb), 32'(w.strb));
                    end
                end
            end
        end
    end

    // phases: random mix, saturated outstanding reads, slow W/B, reset with reads in flight, drain
    initial begin : main
        int pending;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        gen_on = 1'b1;
        repeat (3000) @(posedge clk);
        p_r = 0;
        repeat (40) @(posedge clk);
        p_r = 60;
        p_w = 15; p_b = 20;
        repeat (1000) @(posedge clk);
        p_w = 50; p_b = 60;
        p_r = 0;
        repeat (30) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        p_r = 60;
        repeat (1000) @(posedge clk);
        gen_on = 1'b0;
        p_ar = 100; p_r = 100; p_aw = 100; p_w = 100; p_b = 100;
        pending = 1;
        for (int i = 0; i < 2000 && pending != 0; i++) begin
            @(posedge clk);
            pending = int'(inst_sram_req) + int'(data_sram_req) + inst_exp_q.size() + data_exp_q.size()
                    + ar_exp_q.size() + aw_exp_q.size() + w_exp_q.size();
        end
        chk("drain_pending", 32'(pending), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
